raspi_bus_mux: RTL and testbench

- Parameterised FPGA-side endpoint for the Raspberry Pi 9-bit-style parallel link (data bus, direction line, strobe clock).
- Generalised to DATA_W payload bits plus one control flag bit, NUM_CHAN logical channels, and per-channel RX/TX FIFOs of depth FIFO_DEPTH.
- Host selects a channel with a control word, then streams data words in or out.
- Sits between the top-level RASPI pins and on-chip consumers (link-test echo, firmware loader, debug).

---
 rtl/raspi_bus_mux.sv | 127 ++++++++++++
 tb/tb_raspi_bus_mux.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/raspi_bus_mux.sv
// raspi_bus_mux: host strobe/direction parallel link endpoint with per-channel RX/TX FIFOs
module raspi_bus_mux #(
  parameter int DATA_W      = 8,
  parameter int NUM_CHAN    = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         raspi_clk,
  input  logic                         raspi_dir,
  input  logic [DATA_W:0]              raspi_din,
  output logic [DATA_W:0]              raspi_dout,
  output logic                         raspi_oe,
  output logic [NUM_CHAN-1:0]          rx_valid,
  input  logic [NUM_CHAN-1:0]          rx_ready,
  output logic [NUM_CHAN*DATA_W-1:0]   rx_data,
  input  logic [NUM_CHAN-1:0]          tx_valid,
  output logic [NUM_CHAN-1:0]          tx_ready,
  input  logic [NUM_CHAN*DATA_W-1:0]   tx_data,
  output logic [DATA_W-1:0]            sel_chan,
  output logic [NUM_CHAN-1:0]          rx_overflow,
  output logic                         drop_nosel,
  input  logic                         flags_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] NONE = DATA_W'(NUM_CHAN);
  localparam logic [DATA_W:0] IDLE = '1;
  logic [SYNC_STAGES-1:0] clk_sync_q, dir_sync_q;
  logic clk_prev_q, clk_s, dir_s, strobe, wr_ev, rd_ev;
  logic ctrl, idle, sel_valid, wr_data, pop_word, drop_set, tx_avail, dout_en, oe_q;
  logic [DATA_W-1:0] data, sel_q, sel_d, tx_head;
  logic [DATA_W:0] dout_q, dout_d;
  logic [NUM_CHAN-1:0] ovf_q, ovf_set, tx_empty;
  logic drop_q;
  logic [DATA_W-1:0] tx_head_a [NUM_CHAN];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      clk_sync_q <= '1;
      dir_sync_q <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], raspi_clk};
      dir_sync_q <= {dir_sync_q[SYNC_STAGES-2:0], raspi_dir};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign dir_s     = dir_sync_q[SYNC_STAGES-1];
  assign strobe    = clk_s & ~clk_prev_q;
  assign wr_ev     = strobe & dir_s;
  assign rd_ev     = strobe & ~dir_s;
  assign ctrl      = raspi_din[DATA_W];
  assign data      = raspi_din[DATA_W-1:0];
  assign idle      = &raspi_din;
  assign sel_valid = sel_q < NONE;
  assign wr_data   = wr_ev & ~ctrl & sel_valid;
  assign drop_set  = wr_ev & ~ctrl & ~sel_valid;
  assign pop_word  = rd_ev & ~dout_q[DATA_W];
  assign sel_d     = (wr_ev && ctrl && !idle) ? ((data < NONE) ? data : NONE) : sel_q;
  always_comb begin
    tx_head  = '0;
    tx_avail = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++)
      if (sel_q == DATA_W'(i)) begin
        tx_head  = tx_head_a[i];
        tx_avail = ~tx_empty[i];
      end
  end
  assign dout_d  = tx_avail ? {1'b0, tx_head} : IDLE;
  // dout is frozen while the synced strobe is low so the host always samples a settled word
  assign dout_en = clk_s & ~strobe;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sel_q  <= NONE;
      dout_q <= IDLE;
      oe_q   <= 1'b0;
      ovf_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      dout_q <= dout_en ? dout_d : dout_q;
      oe_q   <= ~dir_s;
      ovf_q  <= ovf_set | (ovf_q & {NUM_CHAN{~flags_clr}});
      drop_q <= drop_set | (drop_q & ~flags_clr);
    end
  assign raspi_dout  = dout_q;
  assign raspi_oe    = oe_q;
  assign sel_chan    = sel_q;
  assign rx_overflow = ovf_q;
  assign drop_nosel  = drop_q;
  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_ch
    logic [AW:0] rwp_q, rrp_q, twp_q, trp_q;
    logic [DATA_W-1:0] rmem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] tmem_q [FIFO_DEPTH];
    logic hit, r_full, r_pop, r_wr, r_push, t_full, t_push, t_pop;
    assign hit      = sel_q == DATA_W'(k);
    assign r_full   = (rwp_q ^ rrp_q) == {1'b1, {AW{1'b0}}};
    assign t_full   = (twp_q ^ trp_q) == {1'b1, {AW{1'b0}}};
    assign rx_valid[k] = rwp_q != rrp_q;
    assign r_pop    = rx_valid[k] & rx_ready[k];
    assign r_wr     = wr_data & hit;
    assign r_push   = r_wr & (~r_full | r_pop);
    assign ovf_set[k] = r_wr & r_full & ~r_pop;
    assign rx_data[k*DATA_W +: DATA_W] = rmem_q[rrp_q[AW-1:0]];
    assign tx_ready[k] = ~t_full;
    assign tx_empty[k] = twp_q == trp_q;
    assign t_push   = tx_valid[k] & ~t_full;
    assign t_pop    = pop_word & hit & ~tx_empty[k];
    assign tx_head_a[k] = tmem_q[trp_q[AW-1:0]];
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        rwp_q <= '0;
        rrp_q <= '0;
        twp_q <= '0;
        trp_q <= '0;
      end else begin
        rwp_q <= rwp_q + (AW+1)'(r_push);
        rrp_q <= rrp_q + (AW+1)'(r_pop);
        twp_q <= twp_q + (AW+1)'(t_push);
        trp_q <= trp_q + (AW+1)'(t_pop);
      end
    always_ff @(posedge clk) begin
      if (r_push) rmem_q[rwp_q[AW-1:0]] <= data;
      if (t_push) tmem_q[twp_q[AW-1:0]] <= tx_data[k*DATA_W +: DATA_W];
    end
  end
endmodule

// File: tb/tb_raspi_bus_mux.sv
// tb_raspi_bus_mux: directed host-link sequence with RX/read scoreboards
module tb_raspi_bus_mux;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0, resetn, raspi_clk, raspi_dir, raspi_oe, drop_nosel, flags_clr;
  logic [W:0] raspi_din, raspi_dout, got;
  logic [N-1:0] rx_valid, rx_ready, tx_valid, tx_ready, rx_overflow;
  logic [N*W-1:0] rx_data, tx_data;
  logic [W-1:0] sel_chan;
  logic [11:0] rx_q[$];
  logic [8:0] rd_q[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  raspi_bus_mux dut (
    .clk(clk), .resetn(resetn), .raspi_clk(raspi_clk), .raspi_dir(raspi_dir),
    .raspi_din(raspi_din), .raspi_dout(raspi_dout), .raspi_oe(raspi_oe),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .sel_chan(sel_chan), .rx_overflow(rx_overflow), .drop_nosel(drop_nosel),
    .flags_clr(flags_clr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic host_write(input logic [8:0] w);
    raspi_dir = 1'b1;
    raspi_din = w;
    wait_n(4);
    raspi_clk = 1'b0;
    wait_n(8);
    raspi_clk = 1'b1;
    wait_n(8);
  endtask
  task automatic host_read(input string tag);
    raspi_dir = 1'b0;
    raspi_clk = 1'b0;
    wait_n(8);
    got = raspi_dout;
    chk("oe_read", {31'd0, raspi_oe}, 32'd1);
    if (rd_q.size() == 0) chk({tag, "_noexp"}, {23'd0, got}, 32'hffff_ffff);
    else chk(tag, {23'd0, got}, {23'd0, rd_q.pop_front()});
    raspi_clk = 1'b1;
    wait_n(8);
  endtask
  task automatic tx_push(input int ch, input logic [7:0] d);
    chk("tx_ready", {31'd0, tx_ready[ch]}, 32'd1);
    tx_valid[ch] = 1'b1;
    tx_data[ch*W +: W] = d;
    wait_n(1);
    tx_valid = '0;
  endtask
  task automatic pulse_clr();
    flags_clr = 1'b1;
    wait_n(1);
    flags_clr = 1'b0;
    wait_n(1);
  endtask
  always @(negedge clk)
    if (resetn)
      for (int k = 0; k < N; k++)
        if (rx_valid[k] && rx_ready[k]) begin
          if (rx_q.size() == 0) chk("rx_unexpected", {20'd0, 4'(k), rx_data[k*W +: W]}, 32'hffff_ffff);
          else chk("rx_word", {20'd0, 4'(k), rx_data[k*W +: W]}, {20'd0, rx_q.pop_front()});
        end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    resetn = 1'b0; raspi_clk = 1'b1; raspi_dir = 1'b1; raspi_din = '1;
    rx_ready = '0; tx_valid = '0; tx_data = '0; flags_clr = 1'b0;
    wait_n(3);
    resetn = 1'b1;
    wait_n(4);
    chk("rst_dout", {23'd0, raspi_dout}, 32'h1ff);
    chk("rst_oe", {31'd0, raspi_oe}, 32'd0);
    chk("rst_sel", {24'd0, sel_chan}, 32'd4);
    chk("rst_rxv", {28'd0, rx_valid}, 32'd0);
    chk("rst_txr", {28'd0, tx_ready}, 32'hf);
    chk("rst_flags", {27'd0, rx_overflow, drop_nosel}, 32'd0);
    raspi_clk = 1'b0;
    wait_n(8);
    chk("fall_nopush", {28'd0, rx_valid}, 32'd0);
    raspi_clk = 1'b1;
    wait_n(8);
    chk("rise_idle", {27'd0, rx_valid, drop_nosel}, 32'd0);
    rx_ready = '1;
    host_write(9'h100);
    chk("sel0", {24'd0, sel_chan}, 32'd0);
    for (int i = 8'h40; i <= 8'h7f; i++) begin
      rx_q.push_back({4'd0, 8'(i)});
      host_write({1'b0, 8'(i)});
    end
    chk("sel_rx_left", rx_q.size(), 32'd0);
    chk("sel_ovf", {28'd0, rx_overflow}, 32'd0);
    chk("sel_rxv", {28'd0, rx_valid}, 32'd0);
    host_write(9'h102);
    chk("sel2", {24'd0, sel_chan}, 32'd2);
    repeat (3) begin
      rd_q.push_back(9'h1ff);
      host_read("rd_empty");
    end
    tx_push(2, 8'hA5);
    tx_push(2, 8'h3C);
    wait_n(3);
    rd_q.push_back(9'h0a5); rd_q.push_back(9'h03c); rd_q.push_back(9'h1ff);
    repeat (3) host_read("rd_data");
    rx_ready = '0;
    host_write(9'h101);
    chk("sel1", {24'd0, sel_chan}, 32'd1);
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) rx_q.push_back({4'd1, 8'(i)});
      host_write({1'b0, 8'(i)});
    end
    chk("ovf_set", {28'd0, rx_overflow}, 32'h2);
    chk("ovf_rxv", {28'd0, rx_valid}, 32'h2);
    pulse_clr();
    chk("ovf_clr", {28'd0, rx_overflow}, 32'd0);
    rx_ready = '1;
    wait_n(20);
    chk("ovf_drain", rx_q.size(), 32'd0);
    chk("ovf_empty", {28'd0, rx_valid}, 32'd0);
    host_write(9'h103);
    chk("sel3", {24'd0, sel_chan}, 32'd3);
    host_write(9'h1ff);
    chk("sync_keep", {24'd0, sel_chan}, 32'd3);
    host_write(9'h105);
    chk("sel_none", {24'd0, sel_chan}, 32'd4);
    host_write(9'h011);
    chk("drop_set", {31'd0, drop_nosel}, 32'd1);
    chk("drop_rxv", {28'd0, rx_valid}, 32'd0);
    pulse_clr();
    chk("drop_clr", {31'd0, drop_nosel}, 32'd0);
    host_write(9'h100);
    for (int i = 0; i < 5; i++) tx_push(0, 8'(8'h11 + i));
    wait_n(3);
    raspi_dir = 1'b0;
    raspi_clk = 1'b0;
    wait_n(8);
    chk("mid_head", {23'd0, raspi_dout}, 32'h011);
    resetn = 1'b0;
    wait_n(2);
    chk("mid_rst_dout", {23'd0, raspi_dout}, 32'h1ff);
    chk("mid_rst_oe", {31'd0, raspi_oe}, 32'd0);
    chk("mid_rst_sel", {24'd0, sel_chan}, 32'd4);
    resetn = 1'b1;
    wait_n(4);
    raspi_clk = 1'b1;
    wait_n(8);
    chk("mid_txr", {28'd0, tx_ready}, 32'hf);
    chk("mid_dout", {23'd0, raspi_dout}, 32'h1ff);
    host_write(9'h100);
    chk("mid_sel0", {24'd0, sel_chan}, 32'd0);
    rd_q.push_back(9'h1ff);
    host_read("mid_read");
    chk("rd_left", rd_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
